// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction fetch stage sitting directly upstream of the next-PC block.
// Owns the architectural PC, issues one instruction-memory read per PC over a
// req/gnt/rvalid handshake and hands the returned word to decode over a
// valid/ready handshake. Fetch is strictly non-speculative: a new request is
// only issued after decode has taken the previous instruction and the next PC
// has been loaded from NPC.
//
// Compile-time option:
//   IFU_ALIGN_CHECK_EN  - when defined, a misaligned NPC seen on the decode
//                         handshake freezes the PC, raises a sticky fetch_err
//                         and parks the FSM in ERR until reset. When not
//                         defined, NPC[1:0] are silently cleared and fetch_err
//                         is tied low.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   NPC          next PC from the next-PC block (sampled on decode handshake)
//   PC           current PC register
//   PC_add_4     PC + 4 (combinational, wraps modulo 2^ADDR_W)
//   imem_req     instruction memory request (high only in FETCH)
//   imem_addr    request address, always equal to PC
//   imem_gnt     memory accepted the request this cycle
//   imem_rvalid  read data valid
//   imem_rdata   instruction word
//   ins          registered instruction to decode
//   ins_valid    ins holds a fetched instruction
//   ins_ready    decode accepts ins this cycle
//   fetch_err    sticky misalignment error (0 unless IFU_ALIGN_CHECK_EN)
//
// States:
//   IDLE  | one-cycle pause after reset, no request
//   FETCH | request asserted at PC, waiting for gnt
//   WAIT  | request accepted, waiting for rvalid
//   HOLD  | instruction presented to decode, waiting for ready
//   ERR   | misaligned NPC seen (option only), frozen until reset
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] NPC,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PC_add_4,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ins,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic              fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3
`ifdef IFU_ALIGN_CHECK_EN
        ,
        S_ERR   = 3'd4
`endif
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ins_q;
    logic              ins_valid_q;

    logic              req_c;
    logic              capture_c;
    logic              take_npc_c;
    logic              raise_err_c;
    logic              handshake;
    logic              npc_misaligned;
    logic [ADDR_W-1:0] npc_aligned;

    assign handshake      = ins_valid_q & ins_ready;
    assign npc_misaligned = |NPC[1:0];
    // Masking rather than slicing keeps every NPC bit in use in both builds.
    assign npc_aligned    = NPC & ~ADDR_W'(3);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and control decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        req_c       = 1'b0;
        capture_c   = 1'b0;
        take_npc_c  = 1'b0;
        raise_err_c = 1'b0;

        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end

            S_FETCH: begin
                // rvalid is deliberately not looked at here; only gnt moves us on.
                req_c = 1'b1;
                if (imem_gnt) begin
                    state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (imem_rvalid) begin
                    capture_c = 1'b1;
                    state_nxt = S_HOLD;
                end
            end

            S_HOLD: begin
                if (handshake) begin
`ifdef IFU_ALIGN_CHECK_EN
                    if (npc_misaligned) begin
                        raise_err_c = 1'b1;
                        state_nxt   = S_ERR;
                    end else begin
                        take_npc_c  = 1'b1;
                        state_nxt   = S_FETCH;
                    end
`else
                    take_npc_c = 1'b1;
                    state_nxt  = S_FETCH;
`endif
                end
            end

`ifdef IFU_ALIGN_CHECK_EN
            S_ERR: begin
                state_nxt = S_ERR;
            end
`endif

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // PC and instruction registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= ADDR_W'(RESET_PC);
            ins_q       <= '0;
            ins_valid_q <= 1'b0;
        end else begin
            if (capture_c) begin
                ins_q       <= imem_rdata;
                ins_valid_q <= 1'b1;
            end
            if (take_npc_c) begin
                pc_q        <= npc_aligned;
                ins_valid_q <= 1'b0;
            end
            if (raise_err_c) begin
                ins_valid_q <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sticky error flag
    // -----------------------------------------------------------------------
`ifdef IFU_ALIGN_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (raise_err_c) begin
            err_q <= 1'b1;
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign PC        = pc_q;
    assign PC_add_4  = pc_q + ADDR_W'(4);
    assign imem_req  = req_c;
    assign imem_addr = pc_q;
    assign ins       = ins_q;
    assign ins_valid = ins_valid_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the next-PC logic. It owns the architectural PC register and drives PC_add_4 to the next-PC block. It fetches one instruction per PC from instruction memory over a req/gnt/rvalid handshake and presents it to decode with a valid/ready handshake. On the decode handshake it loads the returned NPC as the new PC. Fetch is non-speculative: only one instruction is in flight at a time.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
ADDR_W, 32, PC / address width; fixed at 32 in this design.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
NPC  input  32  next PC from the next-PC block, sampled on the decode handshake
PC  output  32  current PC register
PC_add_4  output  32  PC + 4, combinational, feeds the next-PC block
imem_req  output  1  instruction memory request
imem_addr  output  32  request address, equals PC
imem_gnt  input  1  memory accepted the request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  instruction word
ins  output  32  registered instruction to decode
ins_valid  output  1  ins holds a fetched instruction
ins_ready  input  1  decode accepts ins this cycle
fetch_err  output  1  sticky error flag; only driven when IFU_ALIGN_CHECK_EN is defined, else tied 0

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - PC = RESET_PC; PC_add_4 = RESET_PC + 4.
  - ins = 0; ins_valid = 0; imem_req = 0; fetch_err = 0.
  - State = IDLE.
- FSM states:
  - IDLE: imem_req = 0. Always moves to FETCH on the next cycle, so the first request is issued one cycle after reset deasserts.
  - FETCH: imem_req = 1, imem_addr = PC. imem_gnt = 1 moves to WAIT. Otherwise stay, holding req and addr stable. imem_rvalid is ignored in FETCH.
  - WAIT: imem_req = 0. imem_rvalid = 1 captures imem_rdata into ins, sets ins_valid = 1 and moves to HOLD. The earliest rvalid is the cycle after gnt; rvalid in the same cycle as gnt is not supported.
  - HOLD: ins and PC are held stable while ins_valid = 1 and ins_ready = 0. When ins_valid & ins_ready:
    - PC <= NPC;
    - ins_valid <= 0;
    - state moves to FETCH.
  - ERR (only with the option defined): imem_req = 0, ins_valid = 0, PC frozen. Exited only by reset.
- Throughput: minimum 3 cycles per instruction (FETCH with gnt, WAIT with rvalid, HOLD with ready).
- PC_add_4 = PC + 4, modulo 2^32; wrap from 32'hFFFF_FFFC gives 0.
- PC changes only on the HOLD handshake or on reset. NPC is not sampled in any other state.
- ins_ready while ins_valid = 0 has no effect.
- Reset asserted mid-transaction: any in-flight gnt/rvalid is discarded and the FSM restarts from IDLE. The memory side is reset by the same rst.
- imem_gnt or imem_rvalid arriving in a state that does not expect it is ignored.

Optional Feature:
IFU_ALIGN_CHECK_EN.
- Defined: on the HOLD handshake, if NPC[1:0] != 2'b00, PC is not updated, fetch_err is set (sticky until reset) and the FSM enters ERR.
- Undefined: PC <= {NPC[31:2], 2'b00} (low bits silently cleared), fetch_err is tied 0 and there is no ERR state.

Test Plan:
- Reset release, memory always grants with rvalid one cycle later, ins_ready = 1, NPC = PC_add_4 -> first imem_req cycle after reset deasserts; imem_addr sequence 0x3000, 0x3004, 0x3008 at one request per 3 cycles; PC_add_4 = 0x3004 while PC = 0x3000.
- Hold imem_gnt = 0 for 4 cycles in FETCH -> imem_req stays 1 with imem_addr stable at 0x3000; WAIT is entered on the cycle gnt rises.
- ins_ready = 0 for 5 cycles in HOLD with ins = 0x2008_0005 -> ins and ins_valid stay stable and PC stays unchanged; a different NPC driven during the stall is not sampled.
- Jump: accept an instruction at PC 0x3008 with NPC = 0x0000_3040 -> next imem_addr = 0x3040.
- Assert rst while in WAIT, then pulse imem_rvalid after release -> ins_valid stays 0, PC = 0x3000, and the pulse is ignored.
- Misaligned NPC = 0x3042 on handshake:
  - With IFU_ALIGN_CHECK_EN: fetch_err = 1, imem_req stays 0 and PC stays at its prior value.
  - Without: next imem_addr = 0x3040.
